cache_read_arbiter: RTL and testbench
=====================================

# cache_read_arbiter

Shares one downstream cache read port (AR/R channels of `CacheBus`) among `NUM_SRC` upstream requesters, e.g. ICache refill, DCache refill and PTW, in front of the L2/interconnect. AR requests are arbitrated round-robin into a one-entry registered AR buffer, with the source index prepended to the ID. R beats are routed back by that ID prefix. A per-source outstanding-transaction limit stops one requester from exhausting downstream resources.

## Interface
Parameters:
- `NUM_SRC`, 3: number of upstream requesters (≥2).
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 64: R data width.
- `ID_WIDTH`, 2: upstream ID width. Downstream ID width is `ID_WIDTH + SRC_W`, with `SRC_W = $clog2(NUM_SRC)`.
- `USER_WIDTH`, 1: user width.
- `MAX_OUTSTANDING`, 4: maximum in-flight reads per source (≥1).

Ports:
- `clk`, in, 1: clock. Single clock domain.
- `rst`, in, 1: synchronous, active-high reset.
- `src[NUM_SRC]`, `CacheBus.slaver`, intf: upstream read ports.
- `dst`, `CacheBus.masterr`, intf: downstream read port.
- `err_route`, out, 1: sticky flag. Set when an R beat carries an out-of-range source prefix. Cleared only by reset.

## Operation
AR path:
- One-entry AR buffer (`buf_valid`, `buf_ar`) drives `dst.ar_*` directly. `dst.ar_valid = buf_valid`.
- Buffer can accept when `!buf_valid || dst.ar_ready`.
- Eligible source: `src[i].ar_valid && cnt[i] < MAX_OUTSTANDING`.
- When the buffer can accept and at least one source is eligible, the round-robin winner `g` is chosen, starting the search at `rr_ptr`.
  - `src[g].ar_ready = 1`. All other `src[*].ar_ready = 0`.
  - Next cycle: `buf_ar = src[g].ar_*`, with `id = {g[SRC_W-1:0], src[g].ar_id}`. `snoop`, `len`, `size`, `burst` and `user` pass through unchanged.
  - `rr_ptr <= (g+1) mod NUM_SRC`.
- `src[*].ar_ready` is 0 whenever the buffer cannot accept.
- `buf_ar` is stable while `dst.ar_valid && !dst.ar_ready`. This satisfies valid/stability rules.

Outstanding counters `cnt[i]`, width `$clog2(MAX_OUTSTANDING+1)`:
- Increment on the upstream AR handshake of source i. This reserves the slot at acceptance, not at downstream issue.
- Decrement on the downstream R handshake with `r_last` whose prefix is i.
- Increment and decrement in the same cycle: the counter is unchanged.
- The counter never exceeds `MAX_OUTSTANDING` and never underflows. A decrement at 0 is ignored; assertion in simulation.

R path (combinational, no storage):
- `sel = dst.r_id[ID_WIDTH+SRC_W-1 : ID_WIDTH]`.
- `src[sel].r_valid = dst.r_valid`. `src[sel].r_id = dst.r_id[ID_WIDTH-1:0]`.
- `r_data`, `r_resp`, `r_last` and `r_user` are broadcast to all sources. Only `src[sel]` sees valid.
- `dst.r_ready = src[sel].r_ready`.
- If `sel >= NUM_SRC`: `dst.r_ready = 1` and the beat is dropped. `err_route <= 1` on `dst.r_valid`.

## Timing
- Reset values:
  - `buf_valid=0`, hence `dst.ar_valid=0`.
  - All `src[*].ar_ready=0` during reset.
  - `rr_ptr=0`, all `cnt=0`, `err_route=0`.
  - The R path follows its inputs.
- Reset asserted mid-operation discards the buffered AR and clears all counters. R beats still in flight downstream are the system's responsibility; the block raises no error for them.
- AR latency: upstream handshake in cycle N gives `dst.ar_valid` in cycle N+1.
- Sustained throughput is 1 AR/cycle while `dst.ar_ready=1`. A new request is accepted in the same cycle the buffer drains.
- R latency is 0 cycles (pure combinational).
- A source at `MAX_OUTSTANDING` is masked from arbitration. Its request becomes eligible in the cycle after its last-beat handshake (counter registered).
- Fairness: with all sources continuously eligible, grants rotate 0,1,2,0,…

## Structure
- Shared package `cache_arb_pkg`: `SRC_W` function and channel typedefs, built via `CACHE_TYPEDEF_AR_CHAN_T` / `CACHE_TYPEDEF_R_CHAN_T` for upstream and downstream ID widths.
- Sub-module `rr_arbiter #(N)`: inputs `req[N]`, `ptr`; outputs `gnt_onehot`, `gnt_idx`, `any`. Purely combinational. The pointer register lives in `cache_read_arbiter`.
- Estimated RTL: ~200 lines top plus ~60 lines arbiter.

## Test plan
- Single request: src1 AR `addr=0x1000`, `id=2` → `dst.ar_valid` next cycle with `ar_id={2'b01,2'b10}`. R beat `id=0b0110`, `last=1` → delivered on src1 only with `r_id=2`. `cnt[1]` goes 0→1→0.
- All three sources request continuously, `dst.ar_ready=1` → grant order 0,1,2,0,1,2; one AR per cycle; no bubbles.
- Backpressure: hold `dst.ar_ready=0` for 5 cycles with src0 pending → `buf_ar` stable, `src[*].ar_ready=0` throughout. First cycle `ar_ready=1` accepts the next request.
- Outstanding limit, `MAX_OUTSTANDING=4`: src2 issues 4 ARs with no R → 5th held (`ar_ready=0`) while src0 is still granted. After one src2 R last-beat, src2 granted the following cycle. Also drive a simultaneous increment/decrement and check `cnt` is unchanged.
- R backpressure and bursts: 4-beat burst to src0 with `src0.r_ready` toggling → `dst.r_ready` mirrors it. Counter decrements only on the last beat.
- Bad prefix: R with prefix 3 (`NUM_SRC=3`) → `dst.r_ready=1`, no `src[*].r_valid`, `err_route` set and held. Then assert `rst` mid-burst → all outputs return to reset values.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared helpers for the cache read arbiter: source-index width function and
// the AR/R channel struct builders used for both upstream and downstream IDs.
`ifndef CACHE_ARB_TYPEDEFS_SVH
`define CACHE_ARB_TYPEDEFS_SVH
`define CACHE_TYPEDEF_AR_CHAN_T(chan_t, addr_t, id_t, user_t) \
    typedef struct packed {                                   \
        id_t        id;                                       \
        addr_t      addr;                                     \
        logic [3:0] snoop;                                    \
        logic [7:0] len;                                      \
        logic [2:0] size;                                     \
        logic [1:0] burst;                                    \
        user_t      user;                                     \
    } chan_t;
`define CACHE_TYPEDEF_R_CHAN_T(chan_t, data_t, id_t, user_t) \
    typedef struct packed {                                  \
        id_t        id;                                      \
        data_t      data;                                    \
        logic [1:0] resp;                                    \
        logic       last;                                    \
        user_t      user;                                    \
    } chan_t;
`endif

package cache_arb_pkg;

    localparam int unsigned SNOOP_W = 32'd4;
    localparam int unsigned LEN_W   = 32'd8;
    localparam int unsigned SIZE_W  = 32'd3;
    localparam int unsigned BURST_W = 32'd2;
    localparam int unsigned RESP_W  = 32'd2;

    function automatic int unsigned src_w(input int unsigned num_src);
        return (num_src > 32'd1) ? $clog2(num_src) : 32'd1;
    endfunction

    typedef logic [31:0] def_addr_t;
    typedef logic [63:0] def_data_t;
    typedef logic [1:0]  def_up_id_t;
    typedef logic [3:0]  def_dn_id_t;
    typedef logic [0:0]  def_user_t;

    `CACHE_TYPEDEF_AR_CHAN_T(up_ar_chan_t, def_addr_t, def_up_id_t, def_user_t)
    `CACHE_TYPEDEF_AR_CHAN_T(dn_ar_chan_t, def_addr_t, def_dn_id_t, def_user_t)
    `CACHE_TYPEDEF_R_CHAN_T(up_r_chan_t, def_data_t, def_up_id_t, def_user_t)
    `CACHE_TYPEDEF_R_CHAN_T(dn_r_chan_t, def_data_t, def_dn_id_t, def_user_t)

endpackage

// File: rtl/cache_read_arbiter_if.sv
// CacheBus read-only port (AR and R channels) with the two ends as modports:
// masterr issues reads, slaver serves them.
interface CacheBus
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32'd32,
    parameter int unsigned DATA_WIDTH = 32'd64,
    parameter int unsigned ID_WIDTH   = 32'd2,
    parameter int unsigned USER_WIDTH = 32'd1
) ();

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [SNOOP_W-1:0]    ar_snoop;
    logic [LEN_W-1:0]      ar_len;
    logic [SIZE_W-1:0]     ar_size;
    logic [BURST_W-1:0]    ar_burst;
    logic [USER_WIDTH-1:0] ar_user;

    logic                  r_valid;
    logic                  r_ready;
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [RESP_W-1:0]     r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;

    modport masterr (
        output ar_valid, ar_addr, ar_id, ar_snoop, ar_len, ar_size, ar_burst, ar_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user,
        output r_ready
    );

    modport slaver (
        input  ar_valid, ar_addr, ar_id, ar_snoop, ar_len, ar_size, ar_burst, ar_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user,
        input  r_ready
    );

endinterface

// File: rtl/cache_read_arbiter_chk.sv
// Simulation checks on the per-source outstanding counters of cache_read_arbiter.
module cache_read_arbiter_chk #(
    parameter int unsigned NUM_SRC         = 32'd3,
    parameter int unsigned CNT_W           = 32'd3,
    parameter int unsigned MAX_OUTSTANDING = 32'd4
) (
    input logic                            clk_i,
    input logic                            rst_i,
    input logic [NUM_SRC-1:0]              inc_i,
    input logic [NUM_SRC-1:0]              dec_i,
    input logic [NUM_SRC-1:0][CNT_W-1:0]   cnt_i
);

    // A last beat returned for a source with nothing in flight is an unrequested read.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                assert (!(dec_i[i] && !inc_i[i] && (cnt_i[i] == '0)));
                assert (cnt_i[i] <= CNT_W'(MAX_OUTSTANDING));
            end
        end
    end

endmodule

// File: rtl/cache_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr wins.
// The pointer register belongs to the instantiating block.
module rr_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned N = 32'd3
) (
    input  logic [N-1:0]          req,
    input  logic [$clog2(N)-1:0]  ptr,
    output logic [N-1:0]          gnt_onehot,
    output logic [$clog2(N)-1:0]  gnt_idx,
    output logic                  any
);

    localparam int unsigned IDX_W = $clog2(N);

    // Walk the requesters in rotated order; hit is only raised for the first match.
    always_comb begin
        int unsigned j;
        logic        hit;
        j          = 32'd0;
        hit        = 1'b0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j             = (32'(ptr) + k) % N;
            hit           = req[j] & ~any;
            gnt_onehot[j] = hit;
            gnt_idx       = hit ? IDX_W'(j) : gnt_idx;
            any           = any | hit;
        end
    end

endmodule

// File: rtl/cache_read_arbiter.sv
// Shares one downstream cache read port among NUM_SRC requesters: round-robin AR
// arbitration into a one-entry buffer, R beats routed back by the ID prefix.
module cache_read_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC         = 32'd3,
    parameter int unsigned ADDR_WIDTH      = 32'd32,
    parameter int unsigned DATA_WIDTH      = 32'd64,
    parameter int unsigned ID_WIDTH        = 32'd2,
    parameter int unsigned USER_WIDTH      = 32'd1,
    parameter int unsigned MAX_OUTSTANDING = 32'd4
) (
    input  logic     clk,
    input  logic     rst,
    CacheBus.slaver  src [NUM_SRC],
    CacheBus.masterr dst,
    output logic     err_route
);

    localparam int unsigned SRC_W   = src_w(NUM_SRC);
    localparam int unsigned DN_ID_W = ID_WIDTH + SRC_W;
    localparam int unsigned CNT_W   = $clog2(MAX_OUTSTANDING + 32'd1);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ID_WIDTH-1:0]   up_id_t;
    typedef logic [DN_ID_W-1:0]    dn_id_t;
    typedef logic [USER_WIDTH-1:0] user_t;

    `CACHE_TYPEDEF_AR_CHAN_T(up_ar_t, addr_t, up_id_t, user_t)
    `CACHE_TYPEDEF_AR_CHAN_T(dn_ar_t, addr_t, dn_id_t, user_t)
    `CACHE_TYPEDEF_R_CHAN_T(up_r_t, data_t, up_id_t, user_t)

    logic [NUM_SRC-1:0]            ar_valid_s;
    logic [NUM_SRC-1:0]            elig_s;
    logic [NUM_SRC-1:0]            arb_gnt_s;
    logic [NUM_SRC-1:0]            gnt_s;
    logic [NUM_SRC-1:0]            inc_s;
    logic [NUM_SRC-1:0]            dec_s;
    logic [NUM_SRC-1:0]            r_ready_up_s;
    up_ar_t                        ar_up_s [NUM_SRC];
    up_ar_t                        win_s;
    logic [SRC_W-1:0]              arb_idx_s;
    logic                          arb_any_s;
    logic                          can_accept_s;
    logic                          take_s;
    logic [SRC_W-1:0]              sel_s;
    logic                          sel_ok_s;
    logic                          r_ready_s;
    logic                          r_hs_last_s;
    up_r_t                         up_r_s;

    logic                          buf_valid_q, buf_valid_d;
    dn_ar_t                        buf_ar_q, buf_ar_d;
    logic [SRC_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NUM_SRC-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic                          err_route_q, err_route_d;

    // Upstream fan-in/fan-out: gather AR payloads, hand out grants and routed R beats.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign ar_valid_s[i] = src[i].ar_valid;
        assign ar_up_s[i]    = '{id: src[i].ar_id, addr: src[i].ar_addr, snoop: src[i].ar_snoop,
                                 len: src[i].ar_len, size: src[i].ar_size, burst: src[i].ar_burst,
                                 user: src[i].ar_user};
        assign src[i].ar_ready = gnt_s[i];
        assign src[i].r_valid  = dst.r_valid & sel_ok_s & (sel_s == SRC_W'(i));
        assign src[i].r_id     = up_r_s.id;
        assign src[i].r_data   = up_r_s.data;
        assign src[i].r_resp   = up_r_s.resp;
        assign src[i].r_last   = up_r_s.last;
        assign src[i].r_user   = up_r_s.user;
        assign r_ready_up_s[i] = src[i].r_ready;
    end

    rr_arbiter #(.N(NUM_SRC)) u_rr (
        .req        (elig_s),
        .ptr        (rr_ptr_q),
        .gnt_onehot (arb_gnt_s),
        .gnt_idx    (arb_idx_s),
        .any        (arb_any_s)
    );

    // Eligibility and grant qualification; nothing is granted while reset is held.
    always_comb begin
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            elig_s[i] = ar_valid_s[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
        end
        can_accept_s = !buf_valid_q || dst.ar_ready;
        take_s       = arb_any_s && can_accept_s && !rst;
        gnt_s        = arb_gnt_s & {NUM_SRC{take_s}};
        win_s        = ar_up_s[arb_idx_s];
    end

    // AR buffer and pointer next state: refill on a grant, otherwise drain on ready.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_ar_d    = buf_ar_q;
        rr_ptr_d    = rr_ptr_q;
        if (take_s) begin
            buf_valid_d = 1'b1;
            buf_ar_d    = '{id: {arb_idx_s, win_s.id}, addr: win_s.addr, snoop: win_s.snoop,
                            len: win_s.len, size: win_s.size, burst: win_s.burst, user: win_s.user};
            rr_ptr_d    = (arb_idx_s == SRC_W'(NUM_SRC - 32'd1)) ? '0 : arb_idx_s + SRC_W'(1);
        end else begin
            buf_valid_d = buf_valid_q && !dst.ar_ready;
        end
    end

    // R routing: the ID prefix picks the source; unknown prefixes are sunk and flagged.
    always_comb begin
        sel_s       = dst.r_id[DN_ID_W-1:ID_WIDTH];
        sel_ok_s    = ({1'b0, sel_s} < (SRC_W + 1)'(NUM_SRC));
        up_r_s      = '{id: dst.r_id[ID_WIDTH-1:0], data: dst.r_data, resp: dst.r_resp,
                        last: dst.r_last, user: dst.r_user};
        r_ready_s   = sel_ok_s ? r_ready_up_s[sel_s] : 1'b1;
        r_hs_last_s = dst.r_valid && r_ready_s && dst.r_last && sel_ok_s;
        err_route_d = err_route_q | (dst.r_valid & ~sel_ok_s);
    end

    // Outstanding counters: slot reserved at upstream accept, released on the last beat.
    always_comb begin
        cnt_d = cnt_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            inc_s[i] = gnt_s[i];
            dec_s[i] = r_hs_last_s && (sel_s == SRC_W'(i));
            case ({inc_s[i], dec_s[i]})
                2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
                2'b01:   cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CNT_W'(1) : cnt_q[i];
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_ar_q    <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            err_route_q <= 1'b0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_ar_q    <= buf_ar_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            err_route_q <= err_route_d;
        end
    end

    assign dst.ar_valid = buf_valid_q;
    assign dst.ar_id    = buf_ar_q.id;
    assign dst.ar_addr  = buf_ar_q.addr;
    assign dst.ar_snoop = buf_ar_q.snoop;
    assign dst.ar_len   = buf_ar_q.len;
    assign dst.ar_size  = buf_ar_q.size;
    assign dst.ar_burst = buf_ar_q.burst;
    assign dst.ar_user  = buf_ar_q.user;
    assign dst.r_ready  = r_ready_s;
    assign err_route    = err_route_q;

    cache_read_arbiter_chk #(
        .NUM_SRC         (NUM_SRC),
        .CNT_W           (CNT_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .clk_i (clk),
        .rst_i (rst),
        .inc_i (inc_s),
        .dec_i (dec_s),
        .cnt_i (cnt_q)
    );

endmodule

// File: tb/tb_cache_read_arbiter.sv
// Directed bench for cache_read_arbiter: a reference model predicts grants,
// counters and routing; expected downstream ARs go through a scoreboard queue.
module tb_cache_read_arbiter;
    import cache_arb_pkg::*;

    localparam int NS = 3, AW = 32, DW = 64, IW = 2, UW = 1, MAXO = 4, DIW = 4;

    typedef struct packed {
        logic [DIW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [3:0]     snoop;
    } exp_ar_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err_route;
    always #5 clk = ~clk;

    CacheBus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),  .USER_WIDTH(UW)) src_if [NS] ();
    CacheBus #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(DIW), .USER_WIDTH(UW)) dst_if ();

    cache_read_arbiter #(
        .NUM_SRC(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW),
        .USER_WIDTH(UW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src       (src_if),
        .dst       (dst_if),
        .err_route (err_route)
    );

    int             pend [NS];
    logic [NS-1:0]  up_valid;
    logic [AW-1:0]  up_addr [NS];
    logic [IW-1:0]  up_id [NS];
    logic [7:0]     up_len [NS];
    logic [NS-1:0]  up_r_ready;
    logic           dn_ar_ready, dn_r_valid, dn_r_last;
    logic [DIW-1:0] dn_r_id;
    logic [DW-1:0]  dn_r_data;
    logic [NS-1:0]  o_ar_ready, o_r_valid;
    logic [IW-1:0]  o_r_id [NS];
    logic [DW-1:0]  o_r_data [NS];

    exp_ar_t exp_q [$];
    int      m_cnt [NS];
    int      m_rr;
    logic    m_err;
    int      checks = 0;
    int      errors = 0;

    always_comb begin
        for (int i = 0; i < NS; i++) up_valid[i] = (pend[i] > 0);
    end

    for (genvar k = 0; k < NS; k++) begin : g_up
        assign src_if[k].ar_valid = up_valid[k];
        assign src_if[k].ar_addr  = up_addr[k];
        assign src_if[k].ar_id    = up_id[k];
        assign src_if[k].ar_snoop = 4'(k + 1);
        assign src_if[k].ar_len   = up_len[k];
        assign src_if[k].ar_size  = 3'd3;
        assign src_if[k].ar_burst = 2'd1;
        assign src_if[k].ar_user  = 1'b1;
        assign src_if[k].r_ready  = up_r_ready[k];
        assign o_ar_ready[k]      = src_if[k].ar_ready;
        assign o_r_valid[k]       = src_if[k].r_valid;
        assign o_r_id[k]          = src_if[k].r_id;
        assign o_r_data[k]        = src_if[k].r_data;
    end

    assign dst_if.ar_ready = dn_ar_ready;
    assign dst_if.r_valid  = dn_r_valid;
    assign dst_if.r_id     = dn_r_id;
    assign dst_if.r_data   = dn_r_data;
    assign dst_if.r_resp   = 2'b00;
    assign dst_if.r_last   = dn_r_last;
    assign dst_if.r_user   = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic r_set(input logic v, input logic [DIW-1:0] id, input logic last);
        dn_r_valid = v;
        dn_r_id    = id;
        dn_r_last  = last;
        dn_r_data  = {$urandom, $urandom};
    endtask

    // One clock cycle: compare against the model, then advance model and stimulus.
    task automatic step();
        int            g;
        logic          can, sel_ok, e_rr;
        logic [NS-1:0] e_rdy, e_rv;
        int            sel;
        exp_ar_t       e;
        #1;
        g   = -1;
        can = (exp_q.size() == 0) || dn_ar_ready;
        if (!rst && can) begin
            for (int k = 0; k < NS; k++) begin
                int j;
                j = (m_rr + k) % NS;
                if (g < 0 && pend[j] > 0 && m_cnt[j] < MAXO) g = j;
            end
        end
        e_rdy = '0;
        if (g >= 0) e_rdy[g] = 1'b1;
        check("src_ar_ready", o_ar_ready, e_rdy);
        check("dst_ar_valid", dst_if.ar_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            check("dst_ar_id", dst_if.ar_id, e.id);
            check("dst_ar_addr", dst_if.ar_addr, e.addr);
            check("dst_ar_len", dst_if.ar_len, e.len);
            check("dst_ar_snoop", dst_if.ar_snoop, e.snoop);
            check("dst_ar_size_burst_user", {dst_if.ar_size, dst_if.ar_burst, dst_if.ar_user}, 6'b011_01_1);
        end
        sel    = int'(dn_r_id[DIW-1:IW]);
        sel_ok = (sel < NS);
        e_rv   = '0;
        e_rr   = 1'b1;
        if (sel_ok) begin
            e_rv[sel] = dn_r_valid;
            e_rr      = up_r_ready[sel];
        end
        check("src_r_valid", o_r_valid, e_rv);
        check("dst_r_ready", dst_if.r_ready, e_rr);
        if (dn_r_valid && sel_ok) begin
            check("src_r_id", o_r_id[sel], dn_r_id[IW-1:0]);
            check("src_r_data_bcast", o_r_data[(sel + 1) % NS], dn_r_data);
        end
        check("err_route", err_route, m_err);
        for (int i = 0; i < NS; i++) check("cnt", dut.cnt_q[i], m_cnt[i]);
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_rr  = 0;
            m_err = 1'b0;
            for (int i = 0; i < NS; i++) m_cnt[i] = 0;
        end else begin
            if (exp_q.size() != 0 && dn_ar_ready) void'(exp_q.pop_front());
            if (dn_r_valid && e_rr && dn_r_last && sel_ok && m_cnt[sel] > 0) m_cnt[sel]--;
            if (dn_r_valid && !sel_ok) m_err = 1'b1;
            if (g >= 0) begin
                exp_q.push_back('{id: {2'(g), up_id[g]}, addr: up_addr[g], len: up_len[g], snoop: 4'(g + 1)});
                m_rr = (g + 1) % NS;
                m_cnt[g]++;
                pend[g]--;
                up_addr[g] = up_addr[g] + 32'h40;
            end
        end
    endtask

    task automatic drain(input int s, input int n);
        for (int b = 0; b < n; b++) begin
            r_set(1'b1, {2'(s), up_id[s]}, 1'b1);
            step();
        end
        r_set(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        int beat;
        for (int i = 0; i < NS; i++) begin
            pend[i]   = 0;
            m_cnt[i]  = 0;
            up_id[i]  = 2'(i + 1);
            up_len[i] = 8'(i);
            up_addr[i] = 32'h1000 * 32'(i);
        end
        m_rr        = 0;
        m_err       = 1'b0;
        up_r_ready  = '1;
        dn_ar_ready = 1'b1;
        r_set(1'b0, 4'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Single request from src1, then its one-beat read response.
        pend[1] = 1;
        step();
        step();
        r_set(1'b1, 4'b0110, 1'b1);
        step();
        r_set(1'b0, 4'h0, 1'b0);
        step();

        // All sources continuously requesting: rotation, one AR per cycle.
        for (int i = 0; i < NS; i++) pend[i] = 2;
        repeat (8) step();
        for (int s = 0; s < NS; s++) drain(s, 2);

        // Downstream AR backpressure for five cycles.
        dn_ar_ready = 1'b0;
        pend[0] = 2;
        step();
        repeat (5) step();
        dn_ar_ready = 1'b1;
        repeat (3) step();
        drain(0, 2);

        // Outstanding limit on src2 while src0 keeps being served.
        pend[2] = 5;
        pend[0] = 4;
        repeat (10) step();
        drain(2, 1);
        step();
        pend[1] = 1;
        repeat (2) step();
        pend[1] = 1;
        r_set(1'b1, {2'b01, up_id[1]}, 1'b1);
        step();
        r_set(1'b0, 4'h0, 1'b0);
        step();
        drain(0, 4);
        drain(1, 1);
        drain(2, 4);

        // Four-beat burst to src0 with toggling r_ready.
        pend[0] = 1;
        repeat (2) step();
        beat = 0;
        for (int t = 0; t < 12 && beat < 4; t++) begin
            up_r_ready[0] = t[0];
            r_set(1'b1, {2'b00, up_id[0]}, beat == 3);
            step();
            if (up_r_ready[0]) beat++;
        end
        r_set(1'b0, 4'h0, 1'b0);
        up_r_ready = '1;
        step();

        // Out-of-range prefix is sunk and flagged; then reset mid-traffic.
        up_r_ready = '0;
        r_set(1'b1, 4'b1101, 1'b1);
        step();
        r_set(1'b0, 4'h0, 1'b0);
        up_r_ready = '1;
        repeat (3) step();
        dn_ar_ready = 1'b0;
        for (int i = 0; i < NS; i++) pend[i] = 2;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NS; i++) pend[i] = 0;
        step();
        dn_ar_ready = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
